// File: rtl/jk_cmd_conditioner_if.sv
// Command bundle between raw button lines and the JK conditioner outputs.
// slave: the conditioner side (takes raw lines, drives J/K/en/cmd_drop/db_state).
// master: the stimulus side (drives raw lines, observes the command outputs).
interface jk_cmd_conditioner_if;
  logic       raw_set;
  logic       raw_clr;
  logic       raw_tog;
  logic       J;
  logic       K;
  logic       en;
  logic       cmd_drop;
  logic [2:0] db_state;

  modport master (
    output raw_set, raw_clr, raw_tog,
    input  J, K, en, cmd_drop, db_state
  );

  modport slave (
    input  raw_set, raw_clr, raw_tog,
    output J, K, en, cmd_drop, db_state
  );
endinterface

// File: rtl/jk_cmd_conditioner.sv
// Purpose: sync, debounce and edge-detect set/clr/tog lines; arbitrate clr>set>tog into a one-cycle J/K/en command.
// Latency: en registered DB_CYCLES+2 edges after the first edge sampling a stable new raw high level.
// Backpressure: none; no queue, requests losing arbitration are dropped and flagged on cmd_drop. Macro JK_AUTOREPEAT_EN adds tog auto-repeat.
module jk_cmd_conditioner #(
  parameter int DB_CYCLES     = 4,
  parameter int CNT_W         = 16,
  parameter int REPEAT_CYCLES = 8
) (
  input logic                 clk,
  input logic                 reset,
  jk_cmd_conditioner_if.slave cmd
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  // Reject parameter values the counters cannot represent.
  if (DB_CYCLES < 1 || DB_CYCLES > (2 ** CNT_W) - 1 ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("jk_cmd_conditioner: DB_CYCLES/REPEAT_CYCLES out of range for CNT_W");
  end

  // Channel bit order everywhere: [0]=set, [1]=clr, [2]=tog.
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       db;
  logic [2:0]       prev;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       rise;
  logic [2:0]       req;

  logic             j_q;
  logic             k_q;
  logic             en_q;
  logic             drop_q;
  logic             j_d;
  logic             k_d;
  logic             en_d;
  logic             drop_d;

  assign raw  = {cmd.raw_tog, cmd.raw_clr, cmd.raw_set};
  assign rise = db & ~prev;

  // Two-flop synchroniser, per-channel debounce counter and previous-state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      prev  <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef JK_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_hit;

  // Repeat fires only after the initial rising-edge request, so the two never coincide.
  assign rpt_hit = db[2] && prev[2] && (rpt_cnt == RPT_LAST);

  // Repeat counter: loaded with 0 on every tog request so repeats are exactly REPEAT_CYCLES apart.
  always_ff @(posedge clk) begin
    if (reset || !db[2]) begin
      rpt_cnt <= '0;
    end else if (rise[2] || rpt_hit) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + CNT_W'(1);
    end
  end

  assign req = {rise[2] | rpt_hit, rise[1:0]};
`else
  assign req = rise;
`endif

  // Fixed-priority arbitration clr > set > tog; losers raise cmd_drop.
  always_comb begin
    j_d    = 1'b0;
    k_d    = 1'b0;
    en_d   = 1'b0;
    drop_d = 1'b0;
    if (req[1]) begin
      k_d    = 1'b1;
      en_d   = 1'b1;
      drop_d = req[0] | req[2];
    end else if (req[0]) begin
      j_d    = 1'b1;
      en_d   = 1'b1;
      drop_d = req[2];
    end else if (req[2]) begin
      j_d    = 1'b1;
      k_d    = 1'b1;
      en_d   = 1'b1;
    end
  end

  // Registered command outputs; idle is the hold encoding J=K=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      j_q    <= 1'b0;
      k_q    <= 1'b0;
      en_q   <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      j_q    <= j_d;
      k_q    <= k_d;
      en_q   <= en_d;
      drop_q <= drop_d;
    end
  end

  assign cmd.J        = j_q;
  assign cmd.K        = k_q;
  assign cmd.en       = en_q;
  assign cmd.cmd_drop = drop_q;
  assign cmd.db_state = db;

endmodule

// File: tb/tb_jk_cmd_conditioner.sv
// Directed bench for jk_cmd_conditioner: table of single-press vectors plus
// hand sequences for bounce, reset mid-debounce, long tog hold and a JK chain.
module tb_jk_cmd_conditioner;

  localparam int DB  = 4;
  localparam int RPT = 8;
  localparam int LAT = DB + 2;

  logic clk;
  logic reset;

  jk_cmd_conditioner_if bus ();

  jk_cmd_conditioner #(
    .DB_CYCLES    (DB),
    .CNT_W        (16),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .cmd  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   e;
    logic j;
    logic k;
    logic drop;
  } pulse_t;

  typedef struct {
    string      name;
    logic [2:0] raw;   // {tog, clr, set}
    logic       exp_j;
    logic       exp_k;
    logic       exp_drop;
  } vec_t;

  pulse_t pulses[$];
  int     edge_cnt = 0;
  int     idle_bad = 0;
  int     checks   = 0;
  int     failures = 0;
  logic   q_model  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_raw(input logic [2:0] r);
    bus.raw_set = r[0];
    bus.raw_clr = r[1];
    bus.raw_tog = r[2];
  endtask

  // Advance n edges; sample outputs on the falling edge and log every en pulse.
  task automatic run_cycles(input int n);
    pulse_t p;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
      if (bus.en) begin
        p.e    = edge_cnt;
        p.j    = bus.J;
        p.k    = bus.K;
        p.drop = bus.cmd_drop;
        pulses.push_back(p);
        if (bus.J && bus.K)  q_model = ~q_model;
        else if (bus.J)      q_model = 1'b1;
        else if (bus.K)      q_model = 1'b0;
      end else if (bus.J || bus.K || bus.cmd_drop) begin
        idle_bad++;
      end
    end
  endtask

  // Check the first logged pulse against an expected edge and encoding.
  task automatic check_first(input string name, input int t0, input logic j,
                             input logic k, input logic drop);
    if (pulses.size() > 0) begin
      check({name, "_latency"}, pulses[0].e - t0, LAT);
      check({name, "_jk"}, {pulses[0].j, pulses[0].k}, {j, k});
      check({name, "_drop"}, pulses[0].drop, drop);
    end else begin
      check({name, "_latency"}, -1, LAT);
    end
  endtask

  vec_t vecs[7];
  int   t0;
  int   exp_cnt;
  logic [2:0] press_seq [4];

  initial begin
    vecs[0] = '{"set",         3'b001, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"clr",         3'b010, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"tog",         3'b100, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{"set_clr",     3'b011, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{"set_tog",     3'b101, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{"clr_tog",     3'b110, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{"set_clr_tog", 3'b111, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    set_raw(3'b000);
    run_cycles(3);
    check("reset_outputs", {bus.J, bus.K, bus.en, bus.cmd_drop}, 0);
    check("reset_db_state", bus.db_state, 0);
    reset = 1'b0;
    run_cycles(5);
    check("idle_after_reset", pulses.size(), 0);

    // Single clean press per table row, then release and confirm silence.
    foreach (vecs[v]) begin
      pulses.delete();
      t0 = edge_cnt + 1;
      set_raw(vecs[v].raw);
      run_cycles(8);
      check({vecs[v].name, "_db_state"}, bus.db_state, vecs[v].raw);
      set_raw(3'b000);
      run_cycles(14);
      check({vecs[v].name, "_count"}, pulses.size(), 1);
      check_first(vecs[v].name, t0, vecs[v].exp_j, vecs[v].exp_k, vecs[v].exp_drop);
      check({vecs[v].name, "_db_released"}, bus.db_state, 0);
    end

    // Bouncing clr on press and release: one command only, timed from stable level.
    pulses.delete();
    for (int b = 0; b < 4; b++) begin
      set_raw((b % 2 == 0) ? 3'b010 : 3'b000);
      run_cycles(1);
    end
    t0 = edge_cnt + 1;
    set_raw(3'b010);
    run_cycles(8);
    for (int b = 0; b < 4; b++) begin
      set_raw((b % 2 == 0) ? 3'b000 : 3'b010);
      run_cycles(1);
    end
    set_raw(3'b000);
    run_cycles(14);
    check("bounce_count", pulses.size(), 1);
    check_first("bounce", t0, 1'b0, 1'b1, 1'b0);

    // Reset two cycles into a tog debounce, tog still held when reset drops.
    pulses.delete();
    set_raw(3'b100);
    run_cycles(2);
    reset = 1'b1;
    run_cycles(2);
    check("rst_mid_no_cmd", pulses.size(), 0);
    check("rst_mid_db_state", bus.db_state, 0);
    reset = 1'b0;
    t0 = edge_cnt + 1;
    run_cycles(8);
    set_raw(3'b000);
    run_cycles(14);
    check("rst_mid_count", pulses.size(), 1);
    check_first("rst_mid", t0, 1'b1, 1'b1, 1'b0);

    // Long tog hold: one toggle by default, periodic toggles with auto-repeat.
    pulses.delete();
    t0 = edge_cnt + 1;
    set_raw(3'b100);
    run_cycles(40);
    set_raw(3'b000);
    run_cycles(20);
`ifdef JK_AUTOREPEAT_EN
    exp_cnt = 5;
`else
    exp_cnt = 1;
`endif
    check("tog_hold_count", pulses.size(), exp_cnt);
    check_first("tog_hold", t0, 1'b1, 1'b1, 1'b0);
`ifdef JK_AUTOREPEAT_EN
    if (pulses.size() > 1) check("tog_repeat_period", pulses[1].e - pulses[0].e, RPT);
    else check("tog_repeat_period", -1, RPT);
`endif

    // Downstream JK behaviour: set, tog, tog, clr gives Q = 1, 0, 1, 0.
    q_model = 1'b0;
    press_seq[0] = 3'b001;
    press_seq[1] = 3'b100;
    press_seq[2] = 3'b100;
    press_seq[3] = 3'b010;
    for (int s = 0; s < 4; s++) begin
      set_raw(press_seq[s]);
      run_cycles(8);
      set_raw(3'b000);
      run_cycles(14);
      check($sformatf("jk_q_step%0d", s), q_model, (s % 2 == 0) ? 1 : 0);
    end

    check("idle_encoding", idle_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
